// File: rtl/teclado_escaner_param.sv
// teclado_escaner_param
//   Matrix-keypad scanner. Drives one row at a time (one-hot), samples the
//   synchronised columns at the end of each row dwell, reduces a full scan
//   to a single key code (or nothing), debounces on whole-scan results and
//   queues each accepted press in a small FIFO with a valid/ready handshake.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   col_in        : raw column lines (active-high, asynchronous)
//   fila_out      : one-hot row drive
//   tecla         : FIFO head code (fila*COLS + col), 0 when empty
//   tecla_valid   : FIFO non-empty
//   tecla_ready   : consumer takes the head when high with tecla_valid
//   tecla_libre   : one-cycle pulse on an accepted release
//   desborde      : sticky overflow flag (push dropped while full)
//   clr_desborde  : synchronous clear of desborde (a same-cycle set wins)
//   fifo_cnt      : number of entries held
module teclado_escaner_param #(
    parameter  int FILAS     = 4,
    parameter  int COLS      = 4,
    parameter  int DIV_SCAN  = 27000,
    parameter  int DEB_N     = 4,
    parameter  int FIFO_PROF = 4,
    localparam int CODE_W    = $clog2(FILAS*COLS),
    localparam int CNT_W     = $clog2(FIFO_PROF+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_in,
    output logic [FILAS-1:0]  fila_out,
    output logic [CODE_W-1:0] tecla,
    output logic              tecla_valid,
    input  logic              tecla_ready,
    output logic              tecla_libre,
    output logic              desborde,
    input  logic              clr_desborde,
    output logic [CNT_W-1:0]  fifo_cnt
);

    localparam int DW  = $clog2(DIV_SCAN);
    localparam int FW  = (FILAS > 1) ? $clog2(FILAS) : 1;
    localparam int DBW = $clog2(DEB_N+1);
    localparam int AW  = $clog2(FIFO_PROF);

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_RELEASE} estado_t;

    // ---------------- synchroniser and row scan ----------------
    logic [COLS-1:0]   r_col_s1, r_col_s2;
    logic [DW-1:0]     r_div;
    logic [FW-1:0]     r_fila_idx;
    logic [FILAS-1:0]  r_fila;
    logic [1:0]        r_acc_n;      // keys seen so far this scan: 0, 1, 2 = two or more
    logic [CODE_W-1:0] r_acc_code;

    logic              w_tc, w_ultima, w_res_ok;
    logic [1:0]        w_fila_n, w_tot_n;
    logic [CODE_W-1:0] w_fila_code, w_tot_code;

    assign w_tc     = (r_div == DW'(DIV_SCAN-1));
    assign w_ultima = w_tc && (r_fila_idx == FW'(FILAS-1));

    // Keys visible on the current row, saturated at two.
    always_comb begin
        w_fila_n    = '0;
        w_fila_code = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (r_col_s2[c]) begin
                if (w_fila_n == 2'd0)
                    w_fila_code = CODE_W'(32'(r_fila_idx) * COLS + c);
                if (w_fila_n != 2'd2)
                    w_fila_n = w_fila_n + 2'd1;
            end
        end
    end

    // Running scan total including the row being sampled now.
    always_comb begin
        w_tot_code = (w_fila_n == 2'd1) ? w_fila_code : r_acc_code;
        if (r_acc_n == 2'd2 || w_fila_n == 2'd2 || (r_acc_n == 2'd1 && w_fila_n == 2'd1))
            w_tot_n = 2'd2;
        else
            w_tot_n = r_acc_n + w_fila_n;
    end

    assign w_res_ok = (w_tot_n == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_s1   <= '0;
            r_col_s2   <= '0;
            r_div      <= '0;
            r_fila_idx <= '0;
            r_fila     <= FILAS'(1);
            r_acc_n    <= '0;
            r_acc_code <= '0;
        end else begin
            r_col_s1 <= col_in;
            r_col_s2 <= r_col_s1;
            if (w_tc) begin
                r_div  <= '0;
                r_fila <= {r_fila[FILAS-2:0], r_fila[FILAS-1]};
                if (w_ultima) begin
                    r_fila_idx <= '0;
                    r_acc_n    <= '0;
                end else begin
                    r_fila_idx <= r_fila_idx + FW'(1);
                    r_acc_n    <= w_tot_n;
                    r_acc_code <= w_tot_code;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    // ---------------- debounce FSM (one step per full scan) ----------------
    estado_t           r_est;
    logic [CODE_W-1:0] r_cand;
    logic [DBW-1:0]    r_cnt;
    logic              r_push, r_libre;
    logic              w_match, w_deb_lleno;
    logic [DBW-1:0]    w_cnt_inc;

    assign w_match     = w_res_ok && (w_tot_code == r_cand);
    assign w_cnt_inc   = r_cnt + DBW'(1);
    assign w_deb_lleno = (w_cnt_inc >= DBW'(DEB_N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_est   <= S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_push  <= 1'b0;
            r_libre <= 1'b0;
        end else begin
            r_push  <= 1'b0;
            r_libre <= 1'b0;
            if (w_ultima) begin
                unique case (r_est)
                    S_IDLE: begin
                        if (w_res_ok) begin
                            r_cand <= w_tot_code;
                            r_cnt  <= DBW'(1);
                            if (DEB_N == 1) begin
                                r_push <= 1'b1;
                                r_est  <= S_PRESSED;
                            end else begin
                                r_est <= S_CAND;
                            end
                        end
                    end
                    S_CAND: begin
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                            if (w_deb_lleno) begin
                                r_push <= 1'b1;
                                r_est  <= S_PRESSED;
                            end
                        end else if (w_res_ok) begin
                            r_cand <= w_tot_code;
                            r_cnt  <= DBW'(1);
                        end else begin
                            r_est <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (!w_match) begin
                            // With single-scan debounce the first miss is already a release.
                            if (DEB_N == 1) begin
                                r_est   <= S_IDLE;
                                r_libre <= 1'b1;
                            end else begin
                                r_est <= S_RELEASE;
                                r_cnt <= DBW'(1);
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (w_match) begin
                            r_est <= S_PRESSED;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_deb_lleno) begin
                                r_est   <= S_IDLE;
                                r_libre <= 1'b1;
                            end
                        end
                    end
                    default: r_est <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- key FIFO ----------------
    logic [CODE_W-1:0] r_mem [FIFO_PROF];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CNT_W-1:0]  r_cnt_f;
    logic [CODE_W-1:0] r_tecla;
    logic              r_valid, r_desb;

    logic              w_lleno, w_pop, w_push_ok, w_ovf;
    logic [AW-1:0]     w_rp_sig;
    logic [CNT_W-1:0]  w_cnt_sig, w_quedan;

    assign w_lleno   = (r_cnt_f == CNT_W'(FIFO_PROF));
    assign w_pop     = r_valid && tecla_ready;
    assign w_push_ok = r_push && (!w_lleno || w_pop);
    assign w_ovf     = r_push && w_lleno && !w_pop;
    assign w_rp_sig  = r_rp + AW'(w_pop);
    assign w_cnt_sig = r_cnt_f + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    assign w_quedan  = r_cnt_f - CNT_W'(w_pop);

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wp] <= r_cand;
    end

    // Head is registered: computed from the post-edge state so that a push
    // into an emptying FIFO shows the new code directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt_f <= '0;
            r_tecla <= '0;
            r_valid <= 1'b0;
            r_desb  <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wp <= r_wp + AW'(1);
            r_rp    <= w_rp_sig;
            r_cnt_f <= w_cnt_sig;
            r_valid <= (w_cnt_sig != '0);
            if (w_cnt_sig == '0)
                r_tecla <= '0;
            else if (w_quedan == '0)
                r_tecla <= r_cand;
            else
                r_tecla <= r_mem[w_rp_sig];
            if (w_ovf)
                r_desb <= 1'b1;
            else if (clr_desborde)
                r_desb <= 1'b0;
        end
    end

    assign fila_out    = r_fila;
    assign tecla       = r_tecla;
    assign tecla_valid = r_valid;
    assign tecla_libre = r_libre;
    assign desborde    = r_desb;
    assign fifo_cnt    = r_cnt_f;

endmodule
